// File: rtl/uart_cmd_responder_pkg.sv
// Shared definitions for the host debug UART command responder: opcodes,
// FSM state encoding, the refused-read reply value and a state helper.
package uart_cmd_responder_pkg;

    localparam logic [7:0] CMD_WRITE        = 8'h02;
    localparam logic [7:0] CMD_READ         = 8'h03;
    localparam logic [7:0] CMD_HALT         = 8'h06;
    localparam logic [7:0] CMD_RUN          = 8'h07;
    localparam logic [7:0] READ_REFUSED_VAL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_AH  = 3'd1,
        GET_AL  = 3'd2,
        GET_D   = 3'd3,
        BUS_WR  = 3'd4,
        BUS_RD  = 3'd5,
        TX_REQ  = 3'd6,
        TX_WAIT = 3'd7
    } resp_state_t;

    // True while the FSM is collecting command bytes (inter-byte timeout armed).
    function automatic logic is_get_state(input resp_state_t s);
        return (s == GET_AH) || (s == GET_AL) || (s == GET_D);
    endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Saturating inter-byte timeout counter. Cleared on demand, counts while
// enabled, flags expiry when the count reaches TIMEOUT_CYC-1 and holds there.
module cmd_timeout_ctr #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Count up while enabled, saturating at the last value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_cmd_responder.sv
// Host debug UART command endpoint: parses WRITE/READ/HALT/RUN command bytes,
// drives CPU-bus accesses and the CPU halt line, and returns read data to UART_TX.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int   TIMEOUT_CYC = 200000,
    parameter logic HALT_AT_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        cpu_halt,
    output logic        err_pulse
);

    resp_state_t state_r, state_s;
    logic [7:0]  addr_hi_r, addr_hi_s;
    logic [7:0]  addr_lo_r, addr_lo_s;
    logic        is_read_r, is_read_s;
    logic        cpu_halt_r, cpu_halt_s;
    logic        tx_start_r, tx_start_s;
    logic [7:0]  tx_data_r, tx_data_s;
    logic        bus_req_r, bus_req_s;
    logic        bus_we_r, bus_we_s;
    logic [15:0] bus_addr_r, bus_addr_s;
    logic [7:0]  bus_wdata_r, bus_wdata_s;
    logic        err_r, err_s;
    logic        expire_s;

    // Timeout only runs while collecting bytes; any received byte restarts it.
    cmd_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || !is_get_state(state_r)),
        .enable (is_get_state(state_r)),
        .expire (expire_s)
    );

    // Next-state and next-output decode; a received byte always beats a same-cycle timeout.
    always_comb begin
        state_s     = state_r;
        addr_hi_s   = addr_hi_r;
        addr_lo_s   = addr_lo_r;
        is_read_s   = is_read_r;
        cpu_halt_s  = cpu_halt_r;
        tx_start_s  = 1'b0;
        tx_data_s   = tx_data_r;
        bus_req_s   = bus_req_r;
        bus_we_s    = bus_we_r;
        bus_addr_s  = bus_addr_r;
        bus_wdata_s = bus_wdata_r;
        err_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WRITE: begin
                            is_read_s = 1'b0;
                            state_s   = GET_AH;
                        end
                        CMD_READ: begin
                            is_read_s = 1'b1;
                            state_s   = GET_AH;
                        end
                        CMD_HALT: cpu_halt_s = 1'b1;
                        CMD_RUN:  cpu_halt_s = 1'b0;
                        default:  state_s    = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end

            GET_AH: begin
                if (rx_valid) begin
                    addr_hi_s = rx_data;
                    state_s   = GET_AL;
                end else if (expire_s) begin
                    addr_hi_s = 8'h00;
                    addr_lo_s = 8'h00;
                    err_s     = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = GET_AH;
                end
            end

            GET_AL: begin
                if (rx_valid) begin
                    addr_lo_s = rx_data;
                    if (!is_read_r) begin
                        state_s = GET_D;
                    end else if (cpu_halt_r) begin
                        bus_req_s  = 1'b1;
                        bus_we_s   = 1'b0;
                        bus_addr_s = {addr_hi_r, rx_data};
                        state_s    = BUS_RD;
                    end else begin
                        // Refused read still answers so the host stays byte-aligned.
                        tx_data_s = READ_REFUSED_VAL;
                        err_s     = 1'b1;
                        state_s   = TX_REQ;
                    end
                end else if (expire_s) begin
                    addr_hi_s = 8'h00;
                    addr_lo_s = 8'h00;
                    err_s     = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = GET_AL;
                end
            end

            GET_D: begin
                if (rx_valid) begin
                    if (cpu_halt_r) begin
                        bus_req_s   = 1'b1;
                        bus_we_s    = 1'b1;
                        bus_addr_s  = {addr_hi_r, addr_lo_r};
                        bus_wdata_s = rx_data;
                        state_s     = BUS_WR;
                    end else begin
                        err_s   = 1'b1;
                        state_s = IDLE;
                    end
                end else if (expire_s) begin
                    addr_hi_s = 8'h00;
                    addr_lo_s = 8'h00;
                    err_s     = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = GET_D;
                end
            end

            BUS_WR: begin
                err_s = rx_valid;
                if (bus_ack) begin
                    bus_req_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s = BUS_WR;
                end
            end

            BUS_RD: begin
                err_s = rx_valid;
                if (bus_ack) begin
                    bus_req_s = 1'b0;
                    tx_data_s = bus_rdata;
                    state_s   = TX_REQ;
                end else begin
                    state_s = BUS_RD;
                end
            end

            TX_REQ: begin
                err_s = rx_valid;
                if (!tx_active) begin
                    tx_start_s = 1'b1;
                    state_s    = TX_WAIT;
                end else begin
                    state_s = TX_REQ;
                end
            end

            TX_WAIT: begin
                err_s = rx_valid;
                if (tx_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = TX_WAIT;
                end
            end

            default: begin
                bus_req_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any command and releases the bus at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_hi_r   <= 8'h00;
            addr_lo_r   <= 8'h00;
            is_read_r   <= 1'b0;
            cpu_halt_r  <= HALT_AT_RST;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 16'h0000;
            bus_wdata_r <= 8'h00;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_hi_r   <= addr_hi_s;
            addr_lo_r   <= addr_lo_s;
            is_read_r   <= is_read_s;
            cpu_halt_r  <= cpu_halt_s;
            tx_start_r  <= tx_start_s;
            tx_data_r   <= tx_data_s;
            bus_req_r   <= bus_req_s;
            bus_we_r    <= bus_we_s;
            bus_addr_r  <= bus_addr_s;
            bus_wdata_r <= bus_wdata_s;
            err_r       <= err_s;
        end
    end

    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign cpu_halt  = cpu_halt_r;
    assign err_pulse = err_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed protocol scenarios plus
// randomized commands, checked against a per-command behavioural model.
module tb_uart_cmd_responder;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_ack = 1'b0;
    logic        cpu_halt;
    logic        err_pulse;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int txs_cnt = 0;
    int req_cnt = 0;
    logic bus_req_d = 1'b0;
    logic model_halt = 1'b1;

    uart_cmd_responder #(.TIMEOUT_CYC(T), .HALT_AT_RST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .cpu_halt  (cpu_halt),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    // Event counters: error strobes, tx_start strobes and bus_req rising edges.
    always @(negedge clk) begin
        bus_req_d <= bus_req;
        if (err_pulse === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_start === 1'b1) txs_cnt <= txs_cnt + 1;
        if (bus_req === 1'b1 && bus_req_d !== 1'b1) req_cnt <= req_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_expect(input logic [7:0] exp, input bit inject);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", tx_start, 1'b1);
        check("tx_data", tx_data, exp);
        tx_active = 1'b1;
        if (inject) send_byte(8'h02);
        else repeat (2) @(negedge clk);
        check("tx_data_stable", tx_data, exp);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // One whole command; expectations follow from the opcode and the model halt flag.
    task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int dly, input bit inject);
        int e0, r0, t0, exp_err, exp_req, exp_tx;
        logic [7:0] reply;
        settle();
        e0 = err_cnt; r0 = req_cnt; t0 = txs_cnt;
        exp_err = 0; exp_req = 0; exp_tx = 0;
        send_byte(op);
        if (op == 8'h02 || op == 8'h03) begin
            send_byte(addr[15:8]);
            send_byte(addr[7:0]);
            if (op == 8'h02) send_byte(wd);
            if (model_halt) begin
                check("bus_req_rise", bus_req, 1'b1);
                check("bus_we", bus_we, (op == 8'h02));
                check("bus_addr", bus_addr, addr);
                if (op == 8'h02) check("bus_wdata", bus_wdata, wd);
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    check("bus_req_hold", bus_req, 1'b1);
                end
                bus_rdata = rd;
                bus_ack   = 1'b1;
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_rdata = 8'($urandom);
                check("bus_req_drop", bus_req, 1'b0);
                exp_req = 1;
                reply   = rd;
            end else begin
                check("refused_no_req", bus_req, 1'b0);
                exp_err = 1;
                reply   = 8'hFF;
            end
            if (op == 8'h03) begin
                tx_expect(reply, inject);
                exp_tx = 1;
                if (inject) exp_err++;
            end
        end else begin
            if (op == 8'h06) model_halt = 1'b1;
            else if (op == 8'h07) model_halt = 1'b0;
            check("cpu_halt", cpu_halt, model_halt);
        end
        settle();
        check("err_count", err_cnt - e0, exp_err);
        check("req_count", req_cnt - r0, exp_req);
        check("tx_count", txs_cnt - t0, exp_tx);
    endtask

    initial begin
        int e0, r0, sel;
        logic [7:0] op;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 16'h0000);
        check("rst_bus_wdata", bus_wdata, 8'h00);
        check("rst_err", err_pulse, 1'b0);
        check("rst_cpu_halt", cpu_halt, 1'b1);
        rst = 1'b0;
        model_halt = 1'b1;

        // HALT, WRITE with 3-cycle ack, READ of zero
        run_cmd(8'h06, 16'h0000, 8'h00, 8'h00, 0, 1'b0);
        run_cmd(8'h02, 16'h8000, 8'h5A, 8'h00, 3, 1'b0);
        run_cmd(8'h03, 16'hFFFC, 8'h00, 8'h00, 2, 1'b0);

        // Refused accesses while running
        run_cmd(8'h07, 16'h0000, 8'h00, 8'h00, 0, 1'b0);
        run_cmd(8'h02, 16'h0300, 8'h11, 8'h00, 0, 1'b0);
        run_cmd(8'h03, 16'h0300, 8'h00, 8'hA5, 0, 1'b0);
        run_cmd(8'h06, 16'h0000, 8'h00, 8'h00, 0, 1'b0);

        // Partial command times out once, then a fresh READ decodes
        settle();
        e0 = err_cnt;
        send_byte(8'h02);
        send_byte(8'h20);
        repeat (T - 3) @(negedge clk);
        #1;
        check("timeout_not_early", err_cnt - e0, 0);
        repeat (10) @(negedge clk);
        #1;
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_no_req", bus_req, 1'b0);
        run_cmd(8'h03, 16'h0010, 8'h00, 8'h3C, 1, 1'b0);

        // Byte arriving in the expiry cycle is accepted
        settle();
        e0 = err_cnt; r0 = req_cnt;
        send_byte(8'h02);
        repeat (T - 2) @(negedge clk);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        check("race_bus_req", bus_req, 1'b1);
        check("race_bus_addr", bus_addr, 16'h4455);
        check("race_bus_wdata", bus_wdata, 8'h66);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        settle();
        check("race_no_err", err_cnt - e0, 0);
        check("race_one_req", req_cnt - r0, 1);

        // Unknown opcode ignored; RUN then HALT toggle cpu_halt
        run_cmd(8'h55, 16'h0000, 8'h00, 8'h00, 0, 1'b0);
        run_cmd(8'h07, 16'h0000, 8'h00, 8'h00, 0, 1'b0);
        run_cmd(8'h06, 16'h0000, 8'h00, 8'h00, 0, 1'b0);

        // Reset while a read waits for ack
        settle();
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        check("mid_rst_req_before", bus_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bus_req", bus_req, 1'b0);
        check("mid_rst_bus_addr", bus_addr, 16'h0000);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_cpu_halt", cpu_halt, 1'b1);
        check("mid_rst_err", err_pulse, 1'b0);
        rst = 1'b0;
        model_halt = 1'b1;

        // Extra byte during TX_WAIT is dropped with an error
        run_cmd(8'h03, 16'h1234, 8'h00, 8'h9E, 1, 1'b1);
        run_cmd(8'h03, 16'h0005, 8'h00, 8'h77, 0, 1'b0);

        // Randomized command mix
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: op = 8'h02;
                1: op = 8'h03;
                2: op = 8'h06;
                3: op = 8'h07;
                default: op = 8'($urandom_range(8, 255));
            endcase
            run_cmd(op, 16'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 4)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
